// File: rtl/cam_cfg_sequencer.sv
// cam_cfg_sequencer
// Walks the camera register-initialisation ROM and hands one write per entry
// to the SCCB master. Reserved words give an end-of-table marker and an inline
// delay. o_cfg_done stays high after the table finishes and gates the capture
// pipeline. A new start after completion replays the table from entry 0.

module cam_cfg_sequencer #(
   parameter int ADDR_W       = 8,
   parameter int ROM_DEPTH    = 256,
   parameter int DELAY_CYCLES = 2500000
) (
   input  logic              i_sysclk,
   input  logic              i_rst,
   input  logic              i_cfg_start,
   output logic [ADDR_W-1:0] o_rom_addr,
   input  logic [15:0]       i_rom_data,
   output logic              o_sccb_start,
   output logic [7:0]        o_sccb_reg,
   output logic [7:0]        o_sccb_data,
   input  logic              i_sccb_ready,
   output logic              o_busy,
   output logic              o_cfg_done
);

   // The delay counter only has to hold DELAY_CYCLES-1; keep at least one bit
   // so DELAY_CYCLES of 1 still elaborates.
   localparam int                CNT_W      = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(DELAY_CYCLES - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(ROM_DEPTH - 1);
   localparam logic [15:0]       WORD_END   = 16'hFFFF;
   localparam logic [15:0]       WORD_DELAY = 16'hFFF0;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_READ,
      ST_DECODE,
      ST_WAIT_RDY,
      ST_WAIT_ACC,
      ST_WAIT_CMPL,
      ST_DELAY,
      ST_ADVANCE,
      ST_DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] delay_cnt;

   // Sequencer state machine; every output is registered here so the SCCB
   // start pulse is always exactly one cycle and reset clears everything at once.
   always_ff @(posedge i_sysclk) begin
      if (i_rst) begin
         state        <= ST_IDLE;
         delay_cnt    <= '0;
         o_rom_addr   <= '0;
         o_sccb_start <= 1'b0;
         o_sccb_reg   <= 8'h00;
         o_sccb_data  <= 8'h00;
         o_busy       <= 1'b0;
         o_cfg_done   <= 1'b0;
      end else begin
         o_sccb_start <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               o_rom_addr <= '0;
               if (i_cfg_start) begin
                  state      <= ST_READ;
                  o_cfg_done <= 1'b0;
                  o_busy     <= 1'b1;
               end
            end
            ST_READ: begin
               state <= ST_DECODE;
            end
            ST_DECODE: begin
               if (i_rom_data == WORD_END) begin
                  state      <= ST_DONE;
                  o_cfg_done <= 1'b1;
                  o_busy     <= 1'b0;
                  o_rom_addr <= '0;
               end else if (i_rom_data == WORD_DELAY) begin
                  state     <= ST_DELAY;
                  delay_cnt <= CNT_LOAD;
               end else begin
                  state       <= ST_WAIT_RDY;
                  o_sccb_reg  <= i_rom_data[15:8];
                  o_sccb_data <= i_rom_data[7:0];
               end
            end
            ST_WAIT_RDY: begin
               if (i_sccb_ready) begin
                  o_sccb_start <= 1'b1;
                  state        <= ST_WAIT_ACC;
               end
            end
            ST_WAIT_ACC: begin
               if (!i_sccb_ready) begin
                  state <= ST_WAIT_CMPL;
               end
            end
            ST_WAIT_CMPL: begin
               if (i_sccb_ready) begin
                  state <= ST_ADVANCE;
               end
            end
            ST_DELAY: begin
               if (delay_cnt == '0) begin
                  state <= ST_ADVANCE;
               end else begin
                  delay_cnt <= delay_cnt - 1'b1;
               end
            end
            ST_ADVANCE: begin
               if (o_rom_addr == LAST_ADDR) begin
                  state      <= ST_DONE;
                  o_cfg_done <= 1'b1;
                  o_busy     <= 1'b0;
                  o_rom_addr <= '0;
               end else begin
                  state      <= ST_READ;
                  o_rom_addr <= o_rom_addr + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// tb_cam_cfg_sequencer
// Drives cam_cfg_sequencer against a registered ROM model and a simple SCCB
// master model, and compares the issued writes with the list derived directly
// from the table contents.

module tb_cam_cfg_sequencer;

   localparam int ADDR_W       = 8;
   localparam int ROM_DEPTH    = 4;
   localparam int DELAY_CYCLES = 10;

   logic              i_sysclk = 1'b0;
   logic              i_rst;
   logic              i_cfg_start;
   logic [ADDR_W-1:0] o_rom_addr;
   logic [15:0]       i_rom_data;
   logic              o_sccb_start;
   logic [7:0]        o_sccb_reg;
   logic [7:0]        o_sccb_data;
   logic              i_sccb_ready;
   logic              o_busy;
   logic              o_cfg_done;

   cam_cfg_sequencer #(
      .ADDR_W      (ADDR_W),
      .ROM_DEPTH   (ROM_DEPTH),
      .DELAY_CYCLES(DELAY_CYCLES)
   ) dut (
      .i_sysclk    (i_sysclk),
      .i_rst       (i_rst),
      .i_cfg_start (i_cfg_start),
      .o_rom_addr  (o_rom_addr),
      .i_rom_data  (i_rom_data),
      .o_sccb_start(o_sccb_start),
      .o_sccb_reg  (o_sccb_reg),
      .o_sccb_data (o_sccb_data),
      .i_sccb_ready(i_sccb_ready),
      .o_busy      (o_busy),
      .o_cfg_done  (o_cfg_done)
   );

   always #5 i_sysclk = ~i_sysclk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Free-running cycle counter used for latency measurements
   always @(posedge i_sysclk) cyc <= cyc + 1;

   // Config ROM with one cycle of read latency
   logic [15:0] rom [256];
   logic [15:0] rom_q = 16'h0000;
   always @(posedge i_sysclk) rom_q <= rom[o_rom_addr];
   assign i_rom_data = rom_q;

   // SCCB master: accepts a start while ready, then stays busy busy_len cycles
   int busy_len  = 20;
   int busy_cnt  = 0;
   bit force_low = 1'b0;
   always @(posedge i_sysclk) begin
      if (o_sccb_start && i_sccb_ready) busy_cnt <= busy_len;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign i_sccb_ready = (busy_cnt == 0) && !force_low;

   // Monitor: collects issued writes and tracks protocol violations
   logic [15:0] got[$];
   logic [15:0] exp_q[$];
   int          first_pulse_cyc = -1;
   int          start_cyc       = 0;
   int          width_viol      = 0;
   int          rdy_viol        = 0;
   int          stab_viol       = 0;
   bit          prev_start      = 1'b0;
   bit          in_flight       = 1'b0;
   logic [15:0] fl_word         = 16'h0000;
   logic        rdy_q           = 1'b0;

   always @(posedge i_sysclk) rdy_q <= i_sccb_ready;

   always @(negedge i_sysclk) begin
      if (i_rst) begin
         in_flight = 1'b0;
      end else if (o_sccb_start) begin
         if (prev_start) begin
            width_viol++;
         end else begin
            if (!rdy_q) rdy_viol++;
            if (got.size() == 0) first_pulse_cyc = cyc;
            got.push_back({o_sccb_reg, o_sccb_data});
            fl_word   = {o_sccb_reg, o_sccb_data};
            in_flight = 1'b1;
         end
      end else if (in_flight) begin
         if ({o_sccb_reg, o_sccb_data} !== fl_word) stab_viol++;
         if (busy_cnt == 0) in_flight = 1'b0;
      end
      prev_start = o_sccb_start;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Reference: writes in table order, DELAY skipped, stop at END or table end
   task automatic buildExpected();
      exp_q.delete();
      for (int i = 0; i < ROM_DEPTH; i++) begin
         if (rom[i] == 16'hFFFF) break;
         if (rom[i] != 16'hFFF0) exp_q.push_back(rom[i]);
      end
   endtask

   // Reference latency from start to first write with the master always ready
   function automatic int expLatency();
      int lead = 0;
      for (int i = 0; i < ROM_DEPTH; i++) begin
         if (rom[i] != 16'hFFF0) break;
         lead++;
      end
      return 3 + lead * (DELAY_CYCLES + 3);
   endfunction

   function automatic logic [15:0] randWord();
      logic [15:0] w;
      w = 16'($urandom);
      if (w == 16'hFFFF || w == 16'hFFF0) w = 16'h1234;
      return w;
   endfunction

   task automatic fillWrites();
      for (int i = 0; i < 256; i++) rom[i] = randWord();
   endtask

   task automatic applyStimulus();
      @(negedge i_sysclk);
      i_cfg_start = 1'b1;
      @(negedge i_sysclk);
      start_cyc   = cyc;
      i_cfg_start = 1'b0;
   endtask

   task automatic waitDone(input string tag);
      int n = 0;
      while (!o_cfg_done && n < 3000) begin
         @(negedge i_sysclk);
         n++;
      end
      checkOutput({tag, "_done"}, 32'(o_cfg_done), 32'd1);
   endtask

   task automatic compareRun(input string tag);
      checkOutput({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got.size()) checkOutput($sformatf("%s_wr%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
      end
      checkOutput({tag, "_busy"}, 32'(o_busy), 32'd0);
      checkOutput({tag, "_addr"}, 32'(o_rom_addr), 32'd0);
   endtask

   task automatic runTable(input string tag);
      got.delete();
      first_pulse_cyc = -1;
      buildExpected();
      applyStimulus();
      waitDone(tag);
      compareRun(tag);
   endtask

   initial begin
      int lat0;
      int lat1;
      int n;
      int pre;
      int r;

      i_rst       = 1'b1;
      i_cfg_start = 1'b0;
      fillWrites();
      repeat (3) @(negedge i_sysclk);
      checkOutput("rst_addr",  32'(o_rom_addr),   32'd0);
      checkOutput("rst_start", 32'(o_sccb_start), 32'd0);
      checkOutput("rst_reg",   32'(o_sccb_reg),   32'd0);
      checkOutput("rst_data",  32'(o_sccb_data),  32'd0);
      checkOutput("rst_busy",  32'(o_busy),       32'd0);
      checkOutput("rst_done",  32'(o_cfg_done),   32'd0);
      i_rst = 1'b0;

      $display("[TB] basic table");
      busy_len = 3;
      rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
      runTable("basic");
      repeat (10) @(negedge i_sysclk);
      checkOutput("basic_done_held", 32'(o_cfg_done), 32'd1);
      checkOutput("basic_addr_held", 32'(o_rom_addr), 32'd0);

      $display("[TB] delay entry latency");
      rom[0] = 16'h3A04; rom[1] = 16'hFFFF;
      runTable("nodelay");
      lat0 = first_pulse_cyc - start_cyc;
      checkOutput("nodelay_latency", 32'(lat0), 32'(expLatency()));
      rom[0] = 16'hFFF0; rom[1] = 16'h3A04; rom[2] = 16'hFFFF;
      runTable("delay");
      lat1 = first_pulse_cyc - start_cyc;
      checkOutput("delay_latency", 32'(lat1), 32'(expLatency()));
      checkOutput("delay_extra", 32'(lat1 - lat0), 32'(DELAY_CYCLES + 3));

      $display("[TB] slow master, ready held low");
      busy_len  = 20;
      rom[0] = 16'h4501; rom[1] = 16'h4602; rom[2] = 16'hFFFF;
      got.delete();
      first_pulse_cyc = -1;
      buildExpected();
      force_low = 1'b1;
      applyStimulus();
      repeat (7) @(negedge i_sysclk);
      force_low = 1'b0;
      waitDone("slow");
      compareRun("slow");
      checkOutput("slow_latency", 32'(first_pulse_cyc - start_cyc), 32'd8);

      $display("[TB] table without END");
      busy_len = 4;
      fillWrites();
      runTable("noend");
      checkOutput("noend_writes", 32'(got.size()), 32'(ROM_DEPTH));

      $display("[TB] start while busy, then restart");
      rom[0] = 16'h1501; rom[1] = 16'hFFF0; rom[2] = 16'h1602; rom[3] = 16'hFFFF;
      got.delete();
      buildExpected();
      applyStimulus();
      n = 0;
      while (got.size() < 1 && n < 500) begin
         @(negedge i_sysclk);
         n++;
      end
      applyStimulus();
      waitDone("mid");
      compareRun("mid");
      got.delete();
      applyStimulus();
      checkOutput("restart_done_clr", 32'(o_cfg_done), 32'd0);
      checkOutput("restart_busy",     32'(o_busy),     32'd1);
      waitDone("replay");
      compareRun("replay");

      $display("[TB] reset during write completion wait");
      busy_len = 20;
      rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
      got.delete();
      applyStimulus();
      n = 0;
      while (!(got.size() >= 1 && !i_sccb_ready) && n < 500) begin
         @(negedge i_sysclk);
         n++;
      end
      repeat (3) @(negedge i_sysclk);
      checkOutput("prerst_reg", 32'(o_sccb_reg), 32'h12);
      i_rst = 1'b1;
      @(negedge i_sysclk);
      checkOutput("midrst_addr",  32'(o_rom_addr),   32'd0);
      checkOutput("midrst_start", 32'(o_sccb_start), 32'd0);
      checkOutput("midrst_reg",   32'(o_sccb_reg),   32'd0);
      checkOutput("midrst_data",  32'(o_sccb_data),  32'd0);
      checkOutput("midrst_busy",  32'(o_busy),       32'd0);
      checkOutput("midrst_done",  32'(o_cfg_done),   32'd0);
      i_rst = 1'b0;
      runTable("afterrst");

      $display("[TB] randomized tables");
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < 256; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10)      rom[i] = 16'hFFFF;
            else if (r < 25) rom[i] = 16'hFFF0;
            else             rom[i] = randWord();
         end
         busy_len = $urandom_range(2, 10);
         pre      = $urandom_range(0, 6);
         got.delete();
         buildExpected();
         force_low = (pre > 0);
         applyStimulus();
         repeat (pre) @(negedge i_sysclk);
         force_low = 1'b0;
         waitDone($sformatf("rand%0d", it));
         compareRun($sformatf("rand%0d", it));
      end

      checkOutput("pulse_width_viol", 32'(width_viol), 32'd0);
      checkOutput("ready_low_viol",   32'(rdy_viol),   32'd0);
      checkOutput("stability_viol",   32'(stab_viol),  32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
